// File: rtl/srg_32bit_mult_unit_if.sv
// Execute-stage multiplier bus: MULT/MULTU request, MTHI/MTLO writes and the HI/LO result view.
interface srg_32bit_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output start, is_signed, OpA, OpB, hi_we, lo_we, wdata,
        input  busy, done, Hi, Lo
    );

    modport slave (
        input  start, is_signed, OpA, OpB, hi_we, lo_we, wdata,
        output busy, done, Hi, Lo
    );
endinterface

// File: rtl/srg_32bit_mult_unit.sv
// Shift-add 32x32 multiplier with architectural HI/LO: magnitudes are multiplied over
// ITER cycles, then a final SIGN cycle applies the two's complement and writes HI/LO.
module srg_32bit_mult_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input logic                  clk,
    input logic                  rst,
    srg_32bit_mult_unit_if.slave bus
);
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [CW-1:0]        count;
    logic                 neg;
    logic                 done_q;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   raw;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        raw        = {acc, mplier};
        product    = neg ? (~raw + (2*WIDTH)'(1)) : raw;
        // The most negative operand keeps its bit pattern, which is its correct unsigned magnitude.
        mag_a      = (bus.is_signed && bus.OpA[WIDTH-1]) ? (~bus.OpA + WIDTH'(1)) : bus.OpA;
        mag_b      = (bus.is_signed && bus.OpB[WIDTH-1]) ? (~bus.OpB + WIDTH'(1)) : bus.OpB;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (count == CW'(ITER - 1)) state_next = SIGN;
            SIGN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == SIGN);
            case (state)
                IDLE: begin
                    // A start in the same cycle as an MTHI/MTLO wins and the write is lost.
                    if (bus.start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= bus.is_signed & (bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                RUN: begin
                    acc    <= sum[WIDTH:1];
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    count  <= count + CW'(1);
                end
                SIGN: begin
                    hi_q <= product[2*WIDTH-1:WIDTH];
                    lo_q <= product[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_srg_32bit_mult_unit.sv
// Randomized and directed bench for srg_32bit_mult_unit against a plain-arithmetic HI/LO model.
module tb_srg_32bit_mult_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    srg_32bit_mult_unit_if bus ();

    srg_32bit_mult_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product straight from integer arithmetic on the architectural operands.
    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic idleWrite(input string tag, input logic hw, input logic lw, input logic [31:0] data);
        bus.hi_we = hw;
        bus.lo_we = lw;
        bus.wdata = data;
        stepEdge();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (hw) hi_m = data;
        if (lw) lo_m = data;
        checkOutput({tag, "_hi"}, {32'd0, bus.Hi}, {32'd0, hi_m});
        checkOutput({tag, "_lo"}, {32'd0, bus.Lo}, {32'd0, lo_m});
    endtask

    // Waits for done; while busy, HI/LO must hold their pre-operation values.
    task automatic waitDone(input bit inj_start, input bit inj_write, output int cycles, output int bad);
        bit seen = 1'b0;
        cycles = 0;
        bad    = 0;
        while (!seen && cycles < 40) begin
            if (inj_start && cycles == 4) begin
                bus.start     = 1'b1;
                bus.OpA       = 32'd3;
                bus.OpB       = 32'd3;
                bus.is_signed = 1'b0;
            end
            if (inj_write && cycles == 8) begin
                bus.hi_we = 1'b1;
                bus.wdata = 32'hDEADBEEF;
            end
            stepEdge();
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            cycles++;
            if (bus.done) begin
                seen = 1'b1;
            end else if (bus.busy !== 1'b1 || bus.Hi !== hi_m || bus.Lo !== lo_m) begin
                bad++;
            end
        end
        if (!seen) cycles = -1;
    endtask

    // Start is sampled at edge T0; done is seen after the 33rd following edge (the 34th counting T0).
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input bit inj_start, input bit inj_write,
                                 input bit drop_write);
        logic [63:0] p;
        int cycles;
        int bad;
        p = refProduct(a, b, s);
        bus.start     = 1'b1;
        bus.OpA       = a;
        bus.OpB       = b;
        bus.is_signed = s;
        if (drop_write) begin
            bus.hi_we = 1'b1;
            bus.wdata = 32'hBAD0BAD0;
        end
        stepEdge();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.OpA   = $urandom;
        bus.OpB   = $urandom;
        checkOutput({tag, "_busy_after_start"}, {63'd0, bus.busy}, 64'd1);
        checkOutput({tag, "_done_low_after_start"}, {63'd0, bus.done}, 64'd0);
        checkOutput({tag, "_hi_held"}, {32'd0, bus.Hi}, {32'd0, hi_m});
        waitDone(inj_start, inj_write, cycles, bad);
        hi_m = p[63:32];
        lo_m = p[31:0];
        checkOutput({tag, "_latency"}, 64'(cycles), 64'd33);
        checkOutput({tag, "_busy_hold"}, 64'(bad), 64'd0);
        checkOutput({tag, "_hi"}, {32'd0, bus.Hi}, {32'd0, hi_m});
        checkOutput({tag, "_lo"}, {32'd0, bus.Lo}, {32'd0, lo_m});
        checkOutput({tag, "_busy_end"}, {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic watchQuiet(input string tag, input int n);
        int pulses = 0;
        int drift = 0;
        for (int i = 0; i < n; i++) begin
            stepEdge();
            if (bus.done) pulses++;
            if (bus.Hi !== hi_m || bus.Lo !== lo_m || bus.busy !== 1'b0) drift++;
        end
        checkOutput({tag, "_no_done"}, 64'(pulses), 64'd0);
        checkOutput({tag, "_hold"}, 64'(drift), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.OpA       = '0;
        bus.OpB       = '0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wdata     = '0;
        rst           = 1'b1;
        stepEdge();
        stepEdge();
        checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("reset_done", {63'd0, bus.done}, 64'd0);
        checkOutput("reset_hi", {32'd0, bus.Hi}, 64'd0);
        checkOutput("reset_lo", {32'd0, bus.Lo}, 64'd0);
        rst = 1'b0;

        idleWrite("mthi", 1'b1, 1'b0, 32'h12345678);
        idleWrite("mtlo", 1'b0, 1'b1, 32'h9ABCDEF0);

        // Abort mid-RUN with a two-cycle reset.
        bus.start = 1'b1;
        bus.OpA   = 32'h00001234;
        bus.OpB   = 32'h00005678;
        stepEdge();
        bus.start = 1'b0;
        repeat (10) stepEdge();
        rst = 1'b1;
        stepEdge();
        stepEdge();
        rst  = 1'b0;
        hi_m = '0;
        lo_m = '0;
        checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("abort_hi", {32'd0, bus.Hi}, 64'd0);
        checkOutput("abort_lo", {32'd0, bus.Lo}, 64'd0);
        watchQuiet("abort", 40);
        applyStimulus("u7x6", 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus("u_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        stepEdge();
        checkOutput("u_max_done_one_cycle", {63'd0, bus.done}, 64'd0);
        applyStimulus("s_m1x1", 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("s_minxmin", 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("s_m5x0", 32'hFFFFFFFB, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus("ign_start", 32'h00012345, 32'h00000ABC, 1'b0, 1'b1, 1'b0, 1'b0);
        watchQuiet("ign_start", 40);

        applyStimulus("busy_wr", 32'hFFFF0001, 32'h00000777, 1'b1, 1'b0, 1'b1, 1'b0);

        // Chain a start into the done cycle; the simultaneous MTHI must be dropped.
        applyStimulus("b2b_first", 32'h00000005, 32'hFFFFFFF7, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("b2b_second", 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: b = 32'h00000000;
                2: b = 32'hFFFFFFFF;
                default: ;
            endcase
            repeat ($urandom_range(0, 2))
                idleWrite("rnd_wr", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            applyStimulus("rnd", a, b, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/srg_32bit_mult_unit.md
Name: srg_32bit_mult_unit

Overview:
- Multi-cycle 32x32 multiplier for the MIPS execute stage (MULT/MULTU), with architectural HI/LO registers and MTHI/MTLO write ports.
- Sits beside the 32-bit carry-lookahead adder in EX and uses shift-add: one 33-bit partial-product add per cycle.
- Pipeline control stalls on busy; MFHI/MFLO read Hi/Lo directly.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported and verified.
- ITER, 32, number of shift-add iterations. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- OpA  input  32  multiplicand; sampled with start.
- OpB  input  32  multiplier; sampled with start.
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  32  MTHI/MTLO data.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle pulse when Hi/Lo receive a product.
- Hi  output  32  HI register.
- Lo  output  32  LO register.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high. On rst: state=IDLE, busy=0, done=0, Hi=0, Lo=0, internal accumulator/counter=0. rst mid-operation aborts the operation with no Hi/Lo update and no done pulse.
- States: IDLE, RUN, SIGN.
- IDLE, start=1 at edge T0:
  - mcand=|OpA|, mplier=|OpB|. Magnitudes are taken only if is_signed; otherwise the raw values are used. |0x80000000| = 0x80000000 as an unsigned 32-bit value.
  - neg = is_signed & (OpA[31] ^ OpB[31]).
  - acc=0, count=0, state goes to RUN.
- RUN, each edge T1..T32:
  - If mplier[0]=1, {c,acc} = acc + mcand (33-bit result); else c=0.
  - Then {acc,mplier} = {c,acc,mplier} >> 1, and count increments.
  - After the 32nd iteration (edge T32), state goes to SIGN.
- SIGN, edge T33:
  - product = neg ? (~{acc,mplier} + 1) : {acc,mplier}, computed as a 64-bit two's complement.
  - Hi = product[63:32], Lo = product[31:0], state goes to IDLE.
- Outputs and latency:
  - done=1 for exactly the cycle following edge T33.
  - busy=1 from after T0 through T33, and 0 again after T33.
  - Latency is fixed at 34 clocks from the start-sampling edge to Hi/Lo valid, independent of operand values.
- Back-to-back: start may be asserted in the same cycle done=1, since the state is IDLE. That operation is accepted, and done deasserts the next cycle.
- start while busy: ignored and not queued. The pipeline must hold start until it is accepted.
- hi_we/lo_we:
  - In IDLE with start=0: Hi/Lo take wdata at the next edge. hi_we and lo_we together write wdata to both registers.
  - While busy: ignored. Hi/Lo hold their previous values until SIGN writes them.
  - In IDLE with start=1: start has priority and the write is dropped.
- Hi/Lo hold their values indefinitely in IDLE. They change only on rst, on an idle write, or in SIGN.
- Zero operands: a negative-signed zero product (e.g. -5 * 0) gives Hi=Lo=0. Negating 0 yields 0.

Test Plan:
- rst asserted for 2 cycles mid-RUN (count about 10) -> busy=0, done never pulses, Hi=Lo=0. The next start with 7, 6 unsigned gives Hi=0, Lo=0x0000002A after 34 clocks.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> done pulses exactly 34 edges after start, Hi=0xFFFFFFFE, Lo=0x00000001, busy high for the 34-cycle window.
- MULT signed:
  - 0xFFFFFFFF (-1) * 0x00000001 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF.
  - 0x80000000 * 0x80000000 -> Hi=0x40000000, Lo=0x00000000.
  - 0xFFFFFFFB (-5) * 0 -> Hi=Lo=0.
- Second start pulsed at cycle 5 of a busy operation with operands 3, 3 -> ignored. The result equals the first operation only, and there is exactly one done pulse.
- Idle writes and busy writes:
  - Idle: hi_we with wdata=0x12345678, then lo_we with wdata=0x9ABCDEF0 -> Hi=0x12345678, Lo=0x9ABCDEF0.
  - Busy: hi_we with 0xDEADBEEF during RUN -> Hi unchanged until SIGN, then the product.
- Start asserted in the done cycle with 2 * 3 unsigned -> accepted with no idle gap. The second done comes 34 edges later, Lo=6. A simultaneous start+hi_we in IDLE drops the write.
